// File: rtl/hamm_pkg.sv
// hamm_pkg: shared types and constants for the Hamming(7,4) transmit path.
//   state_t      - transmitter FSM states
//   CW_W/DATA_W  - codeword and data nibble widths
//   P1/P2/P4     - parity coverage masks over {d4,d3,d2,d1}
//   hamm74_cw()  - nibble -> codeword {d4,d3,d2,p4,d1,p2,p1}
package hamm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2
  } state_t;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;

  localparam logic [DATA_W-1:0] P1 = 4'b1011;
  localparam logic [DATA_W-1:0] P2 = 4'b1101;
  localparam logic [DATA_W-1:0] P4 = 4'b1110;

  function automatic logic [CW_W-1:0] hamm74_cw(input logic [DATA_W-1:0] d);
    logic p1, p2, p4;
    p1 = ^(d & P1);
    p2 = ^(d & P2);
    p4 = ^(d & P4);
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

endpackage

// File: rtl/hamm74_enc.sv
// hamm74_enc: combinational Hamming(7,4) encoder.
//   d  in  4 : data nibble, d[0]=d1 .. d[3]=d4
//   cw out 7 : codeword {d4,d3,d2,p4,d1,p2,p1}
module hamm74_enc
  import hamm_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  output logic [CW_W-1:0]   cw
);

  assign cw = hamm74_cw(d);

endmodule

// File: rtl/hamm_serial_tx.sv
// hamm_serial_tx: encodes a NIB-nibble word into NIB Hamming(7,4) codewords
// (codeword k = frame[7k+6:7k]) and shifts the frame out LSB-first.
//   clk         in  1      : clock, rising edge
//   rst         in  1      : async active-high reset
//   d_in        in  4*NIB  : data word, nibble k = d_in[4k+3:4k]
//   in_valid    in  1      : d_in valid
//   in_ready    out 1      : word accepted at the next edge if in_valid
//   ser_out     out 1      : serial frame bit
//   ser_valid   out 1      : ser_out carries a frame bit
//   frame_start out 1      : high with frame bit 0
//   frame_last  out 1      : high with frame bit FW-1
//
// state | meaning
// IDLE  | waiting for a word, in_ready high (after first edge out of reset)
// SHIFT | emitting frame bits, one per cycle
// GAPW  | forced idle line for GAP cycles after a frame
module hamm_serial_tx
  import hamm_pkg::*;
#(
  parameter int NIB = 4,
  parameter int GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NIB-1:0]  d_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_last
);

  localparam int FW    = CW_W * NIB;
  localparam int CNT_W = (FW > 1) ? $clog2(FW) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FW - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  logic [FW-1:0]    frame_enc;
  logic [FW-1:0]    shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  state_t           state;

  for (genvar k = 0; k < NIB; k++) begin : g_enc
    hamm74_enc u_enc (
      .d  (d_in[DATA_W*k +: DATA_W]),
      .cw (frame_enc[CW_W*k +: CW_W])
    );
  end

  // After FW shifts the register is all zeros, so the line idles low
  // outside SHIFT without extra gating.
  assign ser_out = shreg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      in_ready    <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg       <= frame_enc;
            bit_cnt     <= '0;
            in_ready    <= 1'b0;
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
            frame_last  <= (FW == 1);
            state       <= SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end

        SHIFT: begin
          shreg       <= shreg >> 1;
          frame_start <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt    <= '0;
            ser_valid  <= 1'b0;
            frame_last <= 1'b0;
            if (GAP > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAPW;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            frame_last <= ((bit_cnt + 1'b1) == LAST_BIT);
          end
        end

        GAPW: begin
          if (gap_cnt == '0) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamm_serial_tx.sv
// Bench for hamm_serial_tx (NIB=4, GAP=2): table vectors, back-to-back
// framing, ignored input during shift, mid-frame reset, random loopback
// through a bench-side single-error corrector.
module tb_hamm_serial_tx;

  localparam int NIB = 4;
  localparam int GAP = 2;
  localparam int FW  = 7 * NIB;

  logic          clk;
  logic          rst;
  logic [15:0]   d_in;
  logic          in_valid;
  logic          in_ready;
  logic          ser_out;
  logic          ser_valid;
  logic          frame_start;
  logic          frame_last;

  hamm_serial_tx #(.NIB(NIB), .GAP(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .frame_last  (frame_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic s;
    logic l;
  } ebit_t;

  typedef struct {
    logic [15:0]   d;
    logic [FW-1:0] f;
  } vec_t;

  ebit_t         exp_q[$];
  logic [FW-1:0] rx_q[$];
  longint        fs_q[$];
  logic [FW-1:0] rx_frame;
  int            rx_idx;
  int            n_vec;
  int            n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent model: positions 1..7, parity p covers positions with bit p set.
  function automatic logic [6:0] enc_model(input logic [3:0] n);
    logic [7:1] pos;
    logic       par;
    pos    = '0;
    pos[3] = n[0];
    pos[5] = n[1];
    pos[6] = n[2];
    pos[7] = n[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int j = 3; j <= 7; j++)
        if ((j & p) != 0) par = par ^ pos[j];
      pos[p] = par;
    end
    return pos[7:1];
  endfunction

  function automatic logic [FW-1:0] enc_frame(input logic [15:0] w);
    logic [FW-1:0] f;
    for (int k = 0; k < NIB; k++) f[7*k +: 7] = enc_model(w[4*k +: 4]);
    return f;
  endfunction

  function automatic logic [3:0] correct(input logic [6:0] c_in);
    logic [6:0] c;
    int         syn;
    c   = c_in;
    syn = int'(c[0] ^ c[2] ^ c[4] ^ c[6])
        + 2 * int'(c[1] ^ c[2] ^ c[5] ^ c[6])
        + 4 * int'(c[3] ^ c[4] ^ c[5] ^ c[6]);
    if (syn != 0) c[syn-1] = ~c[syn-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  task automatic push_frame(input logic [FW-1:0] f);
    ebit_t e;
    for (int i = 0; i < FW; i++) begin
      e.b = f[i];
      e.s = (i == 0);
      e.l = (i == FW - 1);
      exp_q.push_back(e);
    end
  endtask

  // Present a word and wait for acceptance; returns #1 after the accepting edge.
  task automatic send_word(input logic [15:0] d, input logic [FW-1:0] f, input bit keep);
    bit rdy;
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    d_in     = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      rdy = in_ready;
      if (rdy) push_frame(f);
      @(posedge clk);
      #1;
      acc = rdy;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    if (!keep) begin
      in_valid = 1'b0;
      d_in     = 16'($urandom);
    end
  endtask

  task automatic wait_frame(output logic [FW-1:0] f, output bit ok);
    ok = 1'b0;
    f  = '0;
    for (int i = 0; i < 100 && rx_q.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (rx_q.size() == 0) begin
      check("frame_timeout", 32'd0, 32'd1);
    end else begin
      f  = rx_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    ebit_t e;
    if (!rst) begin
      if (ser_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_bit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ser_out", 32'(ser_out), 32'(e.b));
          check("frame_start", 32'(frame_start), 32'(e.s));
          check("frame_last", 32'(frame_last), 32'(e.l));
        end
        if (frame_start) begin
          rx_idx = 0;
          fs_q.push_back($time);
        end
        if (rx_idx < FW) rx_frame[rx_idx] = ser_out;
        rx_idx++;
        if (frame_last) rx_q.push_back(rx_frame);
      end else begin
        check("idle_line", 32'({ser_out, frame_start, frame_last}), 32'd0);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  vec_t          tbl[6];
  logic [FW-1:0] got;
  bit            ok;
  int            cnt;
  logic [15:0]   w;
  logic [15:0]   rec;
  logic [6:0]    c;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rx_idx   = 0;
    rx_frame = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    d_in     = '0;

    tbl[0] = '{16'h000B, 28'h0000055};
    tbl[1] = '{16'hFFFF, 28'hFFFFFFF};
    tbl[2] = '{16'h1111, 28'h0E1C387};
    tbl[3] = '{16'h0000, 28'h0000000};
    tbl[4] = '{16'h0001, 28'h0000007};
    tbl[5] = '{16'hB000, 28'hAA00000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outputs", 32'({ser_out, ser_valid, frame_start, frame_last}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table vectors
    foreach (tbl[i]) begin
      send_word(tbl[i].d, tbl[i].f, 1'b0);
      wait_frame(got, ok);
      if (ok) check("table_frame", 32'(got), 32'(tbl[i].f));
    end

    // Back-to-back with in_valid held high
    repeat (5) @(posedge clk);
    #1;
    fs_q.delete();
    send_word(16'hA5C3, enc_frame(16'hA5C3), 1'b1);
    d_in = 16'h3C5A;
    cnt  = 0;
    while (in_ready == 1'b0 && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("rdy_low_cycles", 32'(cnt), 32'd30);
    send_word(16'h3C5A, enc_frame(16'h3C5A), 1'b0);
    wait_frame(got, ok);
    if (ok) check("b2b_frame_a", 32'(got), 32'(enc_frame(16'hA5C3)));
    wait_frame(got, ok);
    if (ok) check("b2b_frame_b", 32'(got), 32'(enc_frame(16'h3C5A)));
    check("b2b_starts", 32'(fs_q.size()), 32'd2);
    if (fs_q.size() >= 2) check("b2b_spacing", 32'((fs_q[1] - fs_q[0]) / 10), 32'd31);

    // in_valid pulses and d_in toggling during SHIFT are ignored
    send_word(16'h1234, enc_frame(16'h1234), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      in_valid = i[0];
      d_in     = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_frame(got, ok);
    if (ok) check("ignore_frame", 32'(got), 32'(enc_frame(16'h1234)));
    repeat (40) @(posedge clk);
    #1;
    check("no_extra_frame", 32'(rx_q.size()), 32'd0);
    check("no_pending_bits", 32'(exp_q.size()), 32'd0);

    // Mid-frame reset at bit 10
    send_word(16'hBEEF, enc_frame(16'hBEEF), 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("bit10_valid", 32'(ser_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_outputs", 32'({ser_out, ser_valid, frame_start, frame_last}), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready_after", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cnt += int'(ser_valid);
      @(posedge clk);
      #1;
    end
    check("abort_no_bits", 32'(cnt), 32'd0);
    check("abort_no_frame", 32'(rx_q.size()), 32'd0);

    // Random loopback with one flipped bit per codeword
    for (int n = 0; n < 1000; n++) begin
      w = 16'($urandom);
      send_word(w, enc_frame(w), 1'b0);
      wait_frame(got, ok);
      if (ok) begin
        for (int k = 0; k < NIB; k++) begin
          c = got[7*k +: 7];
          c[$urandom_range(6, 0)] ^= 1'b1;
          rec[4*k +: 4] = correct(c);
        end
        check("loopback", 32'(rec), 32'(w));
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
